// File: rtl/multicycle_control_unit_pkg.sv
// Shared opcode, ALU-op and state encodings for the multi-cycle control unit.
package cu_pkg;

  localparam logic [3:0] OP_RTYPE = 4'b0000;
  localparam logic [3:0] OP_ADDI  = 4'b0001;
  localparam logic [3:0] OP_SUBI  = 4'b0010;
  localparam logic [3:0] OP_LW    = 4'b0100;
  localparam logic [3:0] OP_SW    = 4'b0101;
  localparam logic [3:0] OP_BEQ   = 4'b0110;
  localparam logic [3:0] OP_HALT  = 4'b1111;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_ITYPE = 2'b11;

  typedef enum logic [3:0] {
    S_RESET    = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_EXEC_R   = 4'd3,
    S_EXEC_I   = 4'd4,
    S_MEM_ADDR = 4'd5,
    S_MEM_RD   = 4'd6,
    S_MEM_WR   = 4'd7,
    S_WB_ALU   = 4'd8,
    S_WB_MEM   = 4'd9,
    S_BRANCH   = 4'd10,
    S_HALT     = 4'd11
  } state_t;

  typedef struct packed {
    logic       reg_dst;
    logic       branch;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       mem_to_reg;
    logic       alu_src;
    logic [1:0] alu_op;
    logic       pc_write;
    logic       ir_write;
    logic       halted;
  } ctrl_t;

  function automatic logic is_legal(input logic [3:0] op);
    return op inside {OP_RTYPE, OP_ADDI, OP_SUBI, OP_LW, OP_SW, OP_BEQ, OP_HALT};
  endfunction

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Opcode/handshake bus between datapath (slave) and control unit (master).
interface multicycle_control_unit_if #(parameter int COUNT_W = 16);
  logic [3:0]         opcode;
  logic               MemReady;
  logic               RegDst;
  logic               Branch;
  logic               MemRead;
  logic               MemWrite;
  logic               RegWrite;
  logic               MemToReg;
  logic               ALUSrc;
  logic [1:0]         ALUOp;
  logic               PCWrite;
  logic               IRWrite;
  logic               Halted;
  logic               IllegalOp;
  logic               BusError;
  logic [COUNT_W-1:0] InstrCount;

  modport master (
    input  opcode, MemReady,
    output RegDst, Branch, MemRead, MemWrite, RegWrite, MemToReg, ALUSrc,
           ALUOp, PCWrite, IRWrite, Halted, IllegalOp, BusError, InstrCount
  );

  modport slave (
    output opcode, MemReady,
    input  RegDst, Branch, MemRead, MemWrite, RegWrite, MemToReg, ALUSrc,
           ALUOp, PCWrite, IRWrite, Halted, IllegalOp, BusError, InstrCount
  );
endinterface

// File: rtl/multicycle_control_unit_mem_wait_timer.sv
// Counts data-memory wait cycles; expired is combinational from the count.
// Holds at zero while clear is high and saturates once TIMEOUT is reached.
module mem_wait_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [7:0] cnt;

  assign expired = (cnt == 8'(TIMEOUT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && !expired) begin
      cnt <= cnt + 8'd1;
    end
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control FSM; R/I 4, BEQ 3, SW 4+w, LW 5+w cycles.
// Memory states stall on MemReady and abort to FETCH with BusError after MEM_TIMEOUT waits.
module multicycle_control_unit
  import cu_pkg::*;
#(
  parameter int COUNT_W     = 16,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                        clk,
  input  logic                        rst,
  multicycle_control_unit_if.master   bus
);

  state_t             state_q, state_d;
  logic [3:0]         op_q;
  ctrl_t              ctrl;
  logic               in_mem;
  logic               expired;
  logic               abort;
  logic               illegal_dec;
  logic               illegal_q;
  logic               bus_err_q;
  logic [COUNT_W-1:0] count_q;

  assign in_mem      = (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
  assign abort       = in_mem && !bus.MemReady && expired;
  assign illegal_dec = (state_q == S_DECODE) && !is_legal(bus.opcode);

  mem_wait_timer #(.TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (!in_mem),
    .enable  (in_mem && !bus.MemReady),
    .expired (expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_RESET;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RESET:  state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (bus.opcode)
          OP_RTYPE:        state_d = S_EXEC_R;
          OP_ADDI,
          OP_SUBI:         state_d = S_EXEC_I;
          OP_LW,
          OP_SW:           state_d = S_MEM_ADDR;
          OP_BEQ:          state_d = S_BRANCH;
          OP_HALT:         state_d = S_HALT;
          default:         state_d = S_FETCH;
        endcase
      end
      S_EXEC_R,
      S_EXEC_I:   state_d = S_WB_ALU;
      S_MEM_ADDR: state_d = (op_q == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD: begin
        if (bus.MemReady)  state_d = S_WB_MEM;
        else if (abort)    state_d = S_FETCH;
      end
      S_MEM_WR: begin
        if (bus.MemReady || abort) state_d = S_FETCH;
      end
      S_WB_ALU,
      S_WB_MEM,
      S_BRANCH:  state_d = S_FETCH;
      S_HALT:    state_d = S_HALT;
      default:   state_d = S_RESET;
    endcase
  end

  // PCWrite is the only strobe with input terms: the illegal skip, the SW handshake and the abort.
  always_comb begin
    ctrl = '0;
    case (state_q)
      S_FETCH:    ctrl.ir_write = 1'b1;
      S_DECODE:   ctrl.pc_write = !is_legal(bus.opcode);
      S_EXEC_R:   ctrl.alu_op   = ALU_FUNCT;
      S_EXEC_I: begin
        ctrl.alu_src = 1'b1;
        ctrl.alu_op  = ALU_ITYPE;
      end
      S_MEM_ADDR: begin
        ctrl.alu_src = 1'b1;
        ctrl.alu_op  = ALU_ADD;
      end
      S_MEM_RD: begin
        ctrl.alu_src  = 1'b1;
        ctrl.mem_read = 1'b1;
        ctrl.pc_write = abort;
      end
      S_MEM_WR: begin
        ctrl.alu_src   = 1'b1;
        ctrl.mem_write = 1'b1;
        ctrl.pc_write  = bus.MemReady || abort;
      end
      S_WB_ALU: begin
        ctrl.reg_write = 1'b1;
        ctrl.pc_write  = 1'b1;
        if (op_q == OP_RTYPE) begin
          ctrl.reg_dst = 1'b1;
          ctrl.alu_op  = ALU_FUNCT;
        end else begin
          ctrl.alu_src = 1'b1;
          ctrl.alu_op  = ALU_ITYPE;
        end
      end
      S_WB_MEM: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.alu_src    = 1'b1;
        ctrl.pc_write   = 1'b1;
      end
      S_BRANCH: begin
        ctrl.branch   = 1'b1;
        ctrl.alu_op   = ALU_SUB;
        ctrl.pc_write = 1'b1;
      end
      S_HALT:     ctrl.halted = 1'b1;
      default:    ctrl = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q      <= OP_RTYPE;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
      count_q   <= '0;
    end else begin
      if (state_q == S_DECODE) op_q <= bus.opcode;
      if (illegal_dec)         illegal_q <= 1'b1;
      if (abort)               bus_err_q <= 1'b1;
      if (ctrl.pc_write)       count_q <= count_q + 1'b1;
    end
  end

  assign bus.RegDst     = ctrl.reg_dst;
  assign bus.Branch     = ctrl.branch;
  assign bus.MemRead    = ctrl.mem_read;
  assign bus.MemWrite   = ctrl.mem_write;
  assign bus.RegWrite   = ctrl.reg_write;
  assign bus.MemToReg   = ctrl.mem_to_reg;
  assign bus.ALUSrc     = ctrl.alu_src;
  assign bus.ALUOp      = ctrl.alu_op;
  assign bus.PCWrite    = ctrl.pc_write;
  assign bus.IRWrite    = ctrl.ir_write;
  assign bus.Halted     = ctrl.halted;
  assign bus.IllegalOp  = illegal_q;
  assign bus.BusError   = bus_err_q;
  assign bus.InstrCount = count_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench: per-cycle vector table plus hand sequences for waits, timeout, halt, wrap and reset.
module tb_multicycle_control_unit;

  localparam logic [13:0] RD   = 14'h2000;
  localparam logic [13:0] BR   = 14'h1000;
  localparam logic [13:0] MR   = 14'h0800;
  localparam logic [13:0] MW   = 14'h0400;
  localparam logic [13:0] RW   = 14'h0200;
  localparam logic [13:0] M2R  = 14'h0100;
  localparam logic [13:0] ASRC = 14'h0080;
  localparam logic [13:0] A01  = 14'h0020;
  localparam logic [13:0] A10  = 14'h0040;
  localparam logic [13:0] A11  = 14'h0060;
  localparam logic [13:0] PCW  = 14'h0010;
  localparam logic [13:0] IRW  = 14'h0008;
  localparam logic [13:0] HLT  = 14'h0004;
  localparam logic [13:0] ILL  = 14'h0002;
  localparam logic [13:0] BUS  = 14'h0001;

  typedef struct {
    logic [3:0]  op;
    logic        mr;
    logic [13:0] exp;
    logic [3:0]  cnt;
  } vec_t;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  vec_t tbl[$];

  multicycle_control_unit_if #(.COUNT_W(4)) bus ();

  multicycle_control_unit #(.COUNT_W(4), .MEM_TIMEOUT(15)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [13:0] act();
    return {bus.RegDst, bus.Branch, bus.MemRead, bus.MemWrite, bus.RegWrite,
            bus.MemToReg, bus.ALUSrc, bus.ALUOp, bus.PCWrite, bus.IRWrite,
            bus.Halted, bus.IllegalOp, bus.BusError};
  endfunction

  task automatic chk(input string name, input logic [13:0] exp, input logic [3:0] ecnt);
    total++;
    if ({act(), bus.InstrCount} !== {exp, ecnt}) begin
      bad++;
      $display("FAIL %s: got ctrl=%b cnt=%0d, want ctrl=%b cnt=%0d",
               name, act(), bus.InstrCount, exp, ecnt);
    end
  endtask

  // Advance one cycle: inputs change 2 time units after the edge, checks happen at 4.
  task automatic cyc(input logic [3:0] op, input logic mr);
    @(posedge clk);
    #2;
    bus.opcode   = op;
    bus.MemReady = mr;
    #2;
  endtask

  task automatic do_reset();
    #1 rst = 1'b1;
    #1 chk("async_reset", 14'h0, 4'd0);
    @(posedge clk);
    #2;
    rst          = 1'b0;
    bus.opcode   = 4'h0;
    bus.MemReady = 1'b0;
    #2 chk("s_reset", 14'h0, 4'd0);
  endtask

  initial begin
    total        = 0;
    bad          = 0;
    rst          = 1'b0;
    bus.opcode   = 4'h0;
    bus.MemReady = 1'b0;
    #1 rst = 1'b1;

    // RTYPE, LW with 3 waits, BEQ, illegal, ADDI, SW with 1 wait, SUBI
    tbl.push_back('{4'h0, 1'b0, IRW,                    4'd0});
    tbl.push_back('{4'h0, 1'b0, 14'h0,                  4'd0});
    tbl.push_back('{4'h0, 1'b0, A10,                    4'd0});
    tbl.push_back('{4'h0, 1'b0, RW|RD|A10|PCW,          4'd0});
    tbl.push_back('{4'h4, 1'b0, IRW,                    4'd1});
    tbl.push_back('{4'h4, 1'b0, 14'h0,                  4'd1});
    tbl.push_back('{4'h5, 1'b0, ASRC,                   4'd1});
    tbl.push_back('{4'h5, 1'b0, ASRC|MR,                4'd1});
    tbl.push_back('{4'h5, 1'b0, ASRC|MR,                4'd1});
    tbl.push_back('{4'h5, 1'b0, ASRC|MR,                4'd1});
    tbl.push_back('{4'h5, 1'b1, ASRC|MR,                4'd1});
    tbl.push_back('{4'h5, 1'b0, RW|M2R|ASRC|PCW,        4'd1});
    tbl.push_back('{4'h6, 1'b0, IRW,                    4'd2});
    tbl.push_back('{4'h6, 1'b0, 14'h0,                  4'd2});
    tbl.push_back('{4'hA, 1'b0, BR|A01|PCW,             4'd2});
    tbl.push_back('{4'hA, 1'b0, IRW,                    4'd3});
    tbl.push_back('{4'hA, 1'b0, PCW,                    4'd3});
    tbl.push_back('{4'h1, 1'b0, IRW|ILL,                4'd4});
    tbl.push_back('{4'h1, 1'b0, ILL,                    4'd4});
    tbl.push_back('{4'h1, 1'b0, ASRC|A11|ILL,           4'd4});
    tbl.push_back('{4'h5, 1'b0, RW|ASRC|A11|PCW|ILL,    4'd4});
    tbl.push_back('{4'h5, 1'b0, IRW|ILL,                4'd5});
    tbl.push_back('{4'h5, 1'b0, ILL,                    4'd5});
    tbl.push_back('{4'h4, 1'b0, ASRC|ILL,               4'd5});
    tbl.push_back('{4'h4, 1'b0, ASRC|MW|ILL,            4'd5});
    tbl.push_back('{4'h4, 1'b1, ASRC|MW|PCW|ILL,        4'd5});
    tbl.push_back('{4'h2, 1'b1, IRW|ILL,                4'd6});
    tbl.push_back('{4'h2, 1'b1, ILL,                    4'd6});
    tbl.push_back('{4'h2, 1'b1, ASRC|A11|ILL,           4'd6});
    tbl.push_back('{4'h0, 1'b1, RW|ASRC|A11|PCW|ILL,    4'd6});
    tbl.push_back('{4'h0, 1'b0, IRW|ILL,                4'd7});

    do_reset();
    foreach (tbl[i]) begin
      cyc(tbl[i].op, tbl[i].mr);
      chk($sformatf("vec%0d", i), tbl[i].exp, tbl[i].cnt);
    end

    // LW whose MemReady arrives exactly at the timeout count: success, not abort
    do_reset();
    cyc(4'h4, 1'b0); chk("lw_edge_fetch", IRW, 4'd0);
    cyc(4'h4, 1'b0); chk("lw_edge_decode", 14'h0, 4'd0);
    cyc(4'h4, 1'b0); chk("lw_edge_addr", ASRC, 4'd0);
    for (int i = 0; i < 16; i++) begin
      cyc(4'h4, (i == 15));
      chk($sformatf("lw_edge_rd%0d", i), ASRC|MR, 4'd0);
    end
    cyc(4'h0, 1'b0); chk("lw_edge_wb", RW|M2R|ASRC|PCW, 4'd0);

    // SW with MemReady never high: 16 MemWrite cycles, abort pulses PCWrite
    cyc(4'h5, 1'b0); chk("sw_to_fetch", IRW, 4'd1);
    cyc(4'h5, 1'b0); chk("sw_to_decode", 14'h0, 4'd1);
    cyc(4'h5, 1'b0); chk("sw_to_addr", ASRC, 4'd1);
    for (int i = 0; i < 16; i++) begin
      cyc(4'h5, 1'b0);
      chk($sformatf("sw_to_wr%0d", i), (i == 15) ? (ASRC|MW|PCW) : (ASRC|MW), 4'd1);
    end
    cyc(4'h0, 1'b0); chk("sw_to_after", IRW|BUS, 4'd2);

    // HALT absorbs for 20 cycles regardless of MemReady, then async reset leaves it
    do_reset();
    cyc(4'hF, 1'b0); chk("halt_fetch", IRW, 4'd0);
    cyc(4'hF, 1'b0); chk("halt_decode", 14'h0, 4'd0);
    for (int i = 0; i < 20; i++) begin
      cyc(4'h0, 1'(i % 2));
      chk($sformatf("halt_hold%0d", i), HLT, 4'd0);
    end
    do_reset();
    cyc(4'h0, 1'b0); chk("halt_refetch", IRW, 4'd0);

    // 17 ADDIs on a 4-bit counter: wraps 15 -> 0, then reset mid-EXEC_I
    do_reset();
    for (int i = 0; i < 17; i++) begin
      cyc(4'h1, 1'b0); chk($sformatf("wrap_fetch%0d", i), IRW, 4'(i));
      cyc(4'h1, 1'b0);
      cyc(4'h1, 1'b0);
      cyc(4'h1, 1'b0); chk($sformatf("wrap_wb%0d", i), RW|ASRC|A11|PCW, 4'(i));
    end
    cyc(4'h1, 1'b0); chk("mid_fetch", IRW, 4'd1);
    cyc(4'h1, 1'b0); chk("mid_decode", 14'h0, 4'd1);
    cyc(4'h1, 1'b0); chk("mid_exec", ASRC|A11, 4'd1);
    do_reset();
    cyc(4'h0, 1'b0); chk("mid_refetch", IRW, 4'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
